pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline. It drives the write_enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC write enable, resolving four hazard sources: data-memory wait, multi-cycle EX ops, EX-stage branch redirect, and load-use dependencies. It also keeps free-running stall and flush event counters for performance debug.

## Interface
Parameters:
- MD_LATENCY, 4: EX occupancy in cycles of a multi-cycle (mul/div) op; legal range 1..16.
- CNT_W, 32: width of the performance counters.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source register numbers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1 each  the ID instruction actually reads rs1/rs2.
- ex_valid  in  1  EX holds a real instruction (not a bubble).
- ex_rd  in  5  destination register of the EX instruction.
- ex_mem_read  in  1  EX instruction is a load.
- ex_md_start  in  1  EX instruction is a multi-cycle op.
- ex_redirect  in  1  branch/jump in EX resolved taken.
- mem_req  in  1  MEM stage is issuing a data access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_we  out  1  PC update enable.
- if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush, mem_wb_we, mem_wb_flush  out  1 each  stage-register controls; flush overrides we at the register.
- state  out  1  0 = RUN, 1 = MD_BUSY.
- stall_cnt  out  CNT_W  cycles with pc_we = 0.
- flush_cnt  out  CNT_W  redirect events.

## Operation
- Registered state: FSM {RUN, MD_BUSY}, md_cnt (4 bits), stall_cnt, flush_cnt.
- Control outputs are Mealy: combinational from inputs and the registered state. Exactly one action applies per cycle, in this priority:
  1. MEM_STALL (mem_req & ~mem_ready): pc_we, if_id_we, id_ex_we and ex_mem_we = 0. mem_wb_flush = 1, inserting a bubble into WB.
  2. MD_STALL: asserted in RUN when ex_md_start & MD_LATENCY > 1, or in MD_BUSY when md_cnt != 0. pc_we, if_id_we and id_ex_we = 0. ex_mem_flush = 1. mem_wb_we = 1.
  3. REDIRECT (ex_redirect): all we = 1, if_id_flush = 1, id_ex_flush = 1.
  4. LOAD_USE: ex_valid & ex_mem_read & ex_rd != 0 & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)). pc_we and if_id_we = 0. id_ex_flush = 1. ex_mem_we and mem_wb_we = 1.
  5. NORMAL: all we = 1, all flush = 0.
- FSM transitions:
  - RUN -> MD_BUSY when ex_md_start & MD_LATENCY > 1; md_cnt loads MD_LATENCY-2. This happens even under MEM_STALL, because the unit has already started.
  - In MD_BUSY, md_cnt decrements every cycle and saturates at 0.
  - MD_BUSY -> RUN when md_cnt == 0 & ~MEM_STALL. That exit cycle decodes priorities 3–5 normally. Total EX occupancy = MD_LATENCY cycles absent memory stalls.
- ex_redirect is never asserted together with ex_md_start; a bench assertion checks this.
- A redirect under MEM_STALL is not latched: EX is frozen, so ex_redirect stays high and is acted on in the first unstalled cycle.
- Counters: stall_cnt increments on cycles with pc_we = 0. flush_cnt increments on cycles with REDIRECT active. Both wrap modulo 2^CNT_W.

## Timing
- Rst_n low, asynchronously: state = RUN, md_cnt = 0, stall_cnt = 0, flush_cnt = 0. While Rst_n is low, all *_we, all *_flush and pc_we are forced to 0.
- A reset mid-MD_BUSY abandons the op; the stage registers reset alongside.
- Control outputs have zero-cycle latency: they must settle within the cycle they act on and take effect at the next Clk edge.
- Counters and FSM update on the Clk rising edge. Counter outputs lag the event by one cycle.
- MD_LATENCY = 1: the FSM never leaves RUN and ex_md_start is ignored.

## Structure
- Shared package pipe_ctrl_pkg holds the state encoding (ST_RUN, ST_MD_BUSY), REG_ZERO = 5'd0, and the register-number width (5).
- One sub-module: hazard_detect, the purely combinational load-use comparator producing load_use.
- Priority mux, FSM and counters stay in pipeline_ctrl.

## Test plan
- Load-use: ex_valid = 1, ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_rs2_used = 1 -> pc_we = 0, if_id_we = 0, id_ex_flush = 1 for one cycle; stall_cnt +1. Repeat with ex_rd = 0 -> NORMAL.
- Redirect: ex_redirect = 1 for one cycle -> if_id_flush = id_ex_flush = 1, pc_we = 1; flush_cnt = 1 on the next cycle.
- MD op, MD_LATENCY = 4: ex_md_start = 1 -> MD_STALL for 3 cycles (RUN entry + md_cnt 2, 1), NORMAL on the 4th cycle, state back to RUN.
- mem_req = 1, mem_ready = 0 for 3 cycles, with ex_redirect = 1 throughout -> 3 cycles of MEM_STALL with mem_wb_flush = 1, then REDIRECT on the 4th cycle; flush_cnt +1 only once.
- MEM_STALL overlapping MD_BUSY, with md_cnt reaching 0 during the stall -> state stays MD_BUSY until mem_ready, then exits in that cycle.
- Async reset: drop Rst_n mid-MD_BUSY, off the clock edge -> state = RUN and counters = 0 immediately; all controls are 0 while Rst_n is low.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Holds the FSM encoding and register-number constants.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination
// of a load currently in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);

  // x0 never carries a real value, so a load targeting it cannot cause a hazard
  assign load_use = ex_valid && ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline, with the
// multi-cycle EX FSM and free-running stall/flush performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_md_start,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             ex_mem_flush,
  output logic             mem_wb_we,
  output logic             mem_wb_flush,
  output logic             state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam bit         MD_MULTI = (MD_LATENCY > 1);
  localparam logic [3:0] MD_LOAD  = MD_MULTI ? 4'(MD_LATENCY - 2) : 4'd0;

  state_t     state_q;
  logic [3:0] md_cnt;
  logic       load_use;
  logic       mem_stall;
  logic       md_stall;
  logic       md_enter;
  logic       redirect_act;

  hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_valid    (ex_valid),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_stall    = mem_req && !mem_ready;
  assign md_enter     = (state_q == ST_RUN) && ex_md_start && MD_MULTI;
  assign md_stall     = md_enter || ((state_q == ST_MD_BUSY) && (md_cnt != 4'd0));
  assign redirect_act = Rst_n && !mem_stall && !md_stall && ex_redirect;
  assign state        = state_q;

  // Priority decode; every control is held low while reset is asserted
  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_we    = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_we    = 1'b0;
    mem_wb_flush = 1'b0;
    if (Rst_n) begin
      pc_we     = 1'b1;
      if_id_we  = 1'b1;
      id_ex_we  = 1'b1;
      ex_mem_we = 1'b1;
      mem_wb_we = 1'b1;
      if (mem_stall) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_we    = 1'b0;
        mem_wb_flush = 1'b1;
      end else if (md_stall) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_flush = 1'b1;
      end else if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Entry happens even under a memory stall since the unit has already started
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_RUN;
      md_cnt  <= 4'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (md_enter) begin
            state_q <= ST_MD_BUSY;
            md_cnt  <= MD_LOAD;
          end
        end
        ST_MD_BUSY: begin
          if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
          end else if (!mem_stall) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (redirect_act) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule
